icmp_msg_arbiter: RTL and testbench
===================================

// Module: icmp_msg_arbiter
// PURPOSE
//  Shares one ICMP message generator among NREQ requesters (echo-reply, unreachable, time-exceeded engines).
//  Grants one requester, then sequences the generator: type/code/typedata, then three 32-bit payload words.
//  Collects the five 32-bit output beats, forwards them as one framed message and returns ack/err to the requester.
// PARAMETERS
//  NREQ     3   number of requesters, 2..8
//  SELW     2   width of requester index, ceil(log2(NREQ))
//  TIMEOUT  16  max idle cycles waiting for any generator output beat, 1..255
// PORTS
//  clock          in   1        rising-edge clock
//  hardreset_n    in   1        asynchronous, active-low reset
//  req            in   NREQ     request; held high until matching ack pulse
//  req_type       in   8*NREQ   ICMP type per requester (slice i = [8i+7:8i])
//  req_code       in   8*NREQ   ICMP code per requester
//  req_typedata   in   32*NREQ  type-specific header word per requester
//  req_data       in   96*NREQ  IP/datagram payload per requester, word0 = [96i+95:96i+64]
//  ack            out  NREQ     one-cycle completion pulse to the granted requester
//  ack_err        out  1        qualifies ack: 1 = generator timeout, message aborted
//  gen_start      out  1        one-cycle pulse, first load cycle to generator
//  gen_typeoficmp out  8        latched type of granted requester
//  gen_code       out  8        latched code
//  gen_typedata   out  32       latched typedata
//  gen_inputdata  out  32       payload word, one per cycle over 3 cycles starting with gen_start
//  gen_out_valid  in   1        generator output beat valid
//  gen_out_word   in   32       generator output beat
//  out_valid      out  1        forwarded beat valid
//  out_sop        out  1        first beat of message (header+checksum word)
//  out_eop        out  1        fifth beat of message
//  out_word       out  32       forwarded beat
//  out_src        out  SELW     index of requester owning current message
//  busy           out  1        high in every state except IDLE
// BEHAVIOUR
//  Reset (hardreset_n=0, async): all outputs 0, state IDLE, rr_ptr 0, latched fields 0, counters 0.
//  States: IDLE -> LOAD -> FEED1 -> FEED2 -> WAIT -> STREAM -> DONE -> IDLE; WAIT/STREAM -> ERR -> IDLE.
//  IDLE: if any req, grant = first set bit searching from rr_ptr upward, wrapping NREQ-1 -> 0; latch its type/code/typedata/data.
//  LOAD: gen_start=1, gen_inputdata=word0. FEED1: word1. FEED2: word2. gen_inputdata=0 outside these.
//  WAIT: first gen_out_valid -> STREAM with that beat forwarded, out_sop=1, beat_cnt=1.
//  STREAM: each gen_out_valid forwards gen_out_word registered (1-cycle latency); beat_cnt 3-bit; beat 5 sets out_eop -> DONE.
//  Gaps in gen_out_valid allowed; timeout counter (8-bit) clears on each beat, counts otherwise in WAIT/STREAM.
//  Timeout counter reaching TIMEOUT -> ERR; partial message: no out_eop emitted, out_valid stays 0.
//  DONE: ack[grant]=1, ack_err=0; rr_ptr = grant+1 mod NREQ. ERR: ack[grant]=1, ack_err=1; rr_ptr advanced identically.
//  gen_out_valid in IDLE/LOAD/FEED1/FEED2/DONE/ERR: ignored, nothing forwarded.
//  Beats beyond 5 are never forwarded; a valid arriving in DONE is dropped.
//  req deasserted mid-transaction: transaction still completes, ack still pulses; new grants only from IDLE.
//  Requester at grant keeps req high through ack; after ack the same request is not re-granted until IDLE re-arbitrates.
//  out_src stable from grant to return to IDLE; out_sop/out_eop only with out_valid.
//  Async reset mid-message: outputs drop to 0 immediately, no ack issued, rr_ptr returns to 0.
// CONFIGURATION
//  ICMP_ARB_PRIORITY_EN defined: requester 0 has strict priority; others round-robin among themselves.
//  ICMP_ARB_PRIORITY_EN undefined: pure round-robin over all NREQ requesters as above.
// TESTING
//  Single req[1], type=8'h00 code=8'h00, generator echoes 5 beats -> gen_start 1 cycle, 3 payload words in order, out_sop..out_eop 5 beats, ack=3'b010, ack_err=0.
//  req=3'b111 held, 3 messages -> grants 0,1,2 in order; rr_ptr wraps to 0; 4th grant goes to 0.
//  Generator silent after gen_start, TIMEOUT=16 -> ERR 16 cycles after WAIT entry, ack pulse with ack_err=1, no out_valid.
//  Gap of 5 cycles between beats 2 and 3 -> message forwarded intact, no timeout, out_eop on 5th beat only.
//  hardreset_n low during STREAM beat 3 -> out_valid/busy/ack 0 asynchronously; after release next req granted cleanly from 0.
//  With ICMP_ARB_PRIORITY_EN, req=3'b111 held -> grants 0,0,0 ...; req=3'b110 -> grants 1,2,1 alternate.

Source files
------------

// File: rtl/icmp_msg_arbiter.sv
// icmp_msg_arbiter
//   Shares one ICMP message generator among NREQ requesters. A granted requester's
//   type/code/typedata and 96-bit payload are latched. The generator is then loaded
//   over three cycles. Its five 32-bit output beats are forwarded as one framed
//   message, and a one-cycle ack (with ack_err on generator timeout) is returned.
//
//   Optional build macro: ICMP_ARB_PRIORITY_EN
//     defined   -> requester 0 has strict priority, the others round-robin
//     undefined -> pure round-robin over all requesters
//
// Ports
//   clock, hardreset_n        rising-edge clock, asynchronous active-low reset
//   req/req_*                 per-requester request and message fields (packed slices)
//   ack, ack_err              completion pulse to the granted requester, error qualifier
//   gen_start, gen_*          generator load interface (type/code/typedata + 3 payload words)
//   gen_out_valid/word        generator output beats
//   out_valid/sop/eop/word    forwarded framed message (registered, 1-cycle latency)
//   out_src                   index of requester owning the current message
//   busy                      high whenever the arbiter is not idle
`timescale 1ns/1ps
module icmp_msg_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned SELW    = 2,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              hardreset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] req_type,
    input  logic [8*NREQ-1:0] req_code,
    input  logic [32*NREQ-1:0] req_typedata,
    input  logic [96*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   ack,
    output logic              ack_err,
    output logic              gen_start,
    output logic [7:0]        gen_typeoficmp,
    output logic [7:0]        gen_code,
    output logic [31:0]       gen_typedata,
    output logic [31:0]       gen_inputdata,
    input  logic              gen_out_valid,
    input  logic [31:0]       gen_out_word,
    output logic              out_valid,
    output logic              out_sop,
    output logic              out_eop,
    output logic [31:0]       out_word,
    output logic [SELW-1:0]   out_src,
    output logic              busy
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StFeed1  = 3'd2;
    localparam logic [2:0] StFeed2  = 3'd3;
    localparam logic [2:0] StWait   = 3'd4;
    localparam logic [2:0] StStream = 3'd5;
    localparam logic [2:0] StDone   = 3'd6;
    localparam logic [2:0] StErr    = 3'd7;

    logic [2:0]      state_q, state_d;
    logic [SELW-1:0] grant_q, grant_d;
    logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0]      type_q, type_d;
    logic [7:0]      code_q, code_d;
    logic [31:0]     typedata_q, typedata_d;
    logic [95:0]     data_q, data_d;
    logic [2:0]      beat_cnt_q, beat_cnt_d;
    logic [7:0]      to_cnt_q, to_cnt_d;
    logic            out_valid_q, out_valid_d;
    logic            out_sop_q, out_sop_d;
    logic            out_eop_q, out_eop_d;
    logic [31:0]     out_word_q, out_word_d;

    // Arbitration: first eligible request at or above rr_ptr, wrapping.
    logic [NREQ-1:0] req_elig;
    logic [SELW-1:0] pick;
    logic [SELW-1:0] idx;
    logic            pick_vld;

    always_comb begin
        req_elig = req;
`ifdef ICMP_ARB_PRIORITY_EN
        // Requester 0 masks everyone else; otherwise the wrap search skips it naturally.
        if (req[0]) begin
            req_elig = {{(NREQ-1){1'b0}}, 1'b1};
        end
`endif
        pick     = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = SELW'((32'(rr_ptr_q) + i) % NREQ);
            if (!pick_vld && req_elig[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        type_d      = type_q;
        code_d      = code_q;
        typedata_d  = typedata_q;
        data_d      = data_q;
        beat_cnt_d  = beat_cnt_q;
        to_cnt_d    = to_cnt_q;
        out_valid_d = 1'b0;
        out_sop_d   = 1'b0;
        out_eop_d   = 1'b0;
        out_word_d  = '0;

        case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    grant_d    = pick;
                    type_d     = req_type[8*pick +: 8];
                    code_d     = req_code[8*pick +: 8];
                    typedata_d = req_typedata[32*pick +: 32];
                    data_d     = req_data[96*pick +: 96];
                    state_d    = StLoad;
                end
            end
            StLoad:  state_d = StFeed1;
            StFeed1: state_d = StFeed2;
            StFeed2: begin
                beat_cnt_d = '0;
                to_cnt_d   = '0;
                state_d    = StWait;
            end
            StWait, StStream: begin
                if (gen_out_valid) begin
                    out_valid_d = 1'b1;
                    out_word_d  = gen_out_word;
                    out_sop_d   = (state_q == StWait);
                    beat_cnt_d  = beat_cnt_q + 3'd1;
                    to_cnt_d    = '0;
                    if (beat_cnt_q == 3'd4) begin
                        out_eop_d = 1'b1;
                        state_d   = StDone;
                    end else begin
                        state_d = StStream;
                    end
                end else if (to_cnt_q + 8'd1 == 8'(TIMEOUT)) begin
                    // Abort: already-forwarded beats stand, no eop is ever sent.
                    state_d = StErr;
                end else begin
                    to_cnt_d = to_cnt_q + 8'd1;
                end
            end
            StDone, StErr: begin
                rr_ptr_d = (grant_q == SELW'(NREQ - 1)) ? '0 : grant_q + SELW'(1);
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge hardreset_n) begin
        if (!hardreset_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            type_q      <= '0;
            code_q      <= '0;
            typedata_q  <= '0;
            data_q      <= '0;
            beat_cnt_q  <= '0;
            to_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            type_q      <= type_d;
            code_q      <= code_d;
            typedata_q  <= typedata_d;
            data_q      <= data_d;
            beat_cnt_q  <= beat_cnt_d;
            to_cnt_q    <= to_cnt_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_word_q  <= out_word_d;
        end
    end

    logic ack_any;

    always_comb begin
        ack_any       = (state_q == StDone) || (state_q == StErr);
        ack_err       = (state_q == StErr);
        gen_start     = (state_q == StLoad);
        busy          = (state_q != StIdle);
        gen_inputdata = '0;
        case (state_q)
            StLoad:  gen_inputdata = data_q[95:64];
            StFeed1: gen_inputdata = data_q[63:32];
            StFeed2: gen_inputdata = data_q[31:0];
            default: gen_inputdata = '0;
        endcase
        for (int unsigned i = 0; i < NREQ; i++) begin
            ack[i] = ack_any && (grant_q == SELW'(i));
        end
    end

    assign gen_typeoficmp = type_q;
    assign gen_code       = code_q;
    assign gen_typedata   = typedata_q;
    assign out_valid      = out_valid_q;
    assign out_sop        = out_sop_q;
    assign out_eop        = out_eop_q;
    assign out_word       = out_word_q;
    assign out_src        = grant_q;

endmodule

// File: tb/tb_icmp_msg_arbiter.sv
`timescale 1ns/1ps
module tb_icmp_msg_arbiter;

    localparam int unsigned NREQ    = 3;
    localparam int unsigned SELW    = 2;
    localparam int unsigned TIMEOUT = 16;

    logic               clock;
    logic               hardreset_n;
    logic [NREQ-1:0]    req;
    logic [8*NREQ-1:0]  req_type;
    logic [8*NREQ-1:0]  req_code;
    logic [32*NREQ-1:0] req_typedata;
    logic [96*NREQ-1:0] req_data;
    logic [NREQ-1:0]    ack;
    logic               ack_err;
    logic               gen_start;
    logic [7:0]         gen_typeoficmp;
    logic [7:0]         gen_code;
    logic [31:0]        gen_typedata;
    logic [31:0]        gen_inputdata;
    logic               gen_out_valid;
    logic [31:0]        gen_out_word;
    logic               out_valid;
    logic               out_sop;
    logic               out_eop;
    logic [31:0]        out_word;
    logic [SELW-1:0]    out_src;
    logic               busy;

    icmp_msg_arbiter #(
        .NREQ    (NREQ),
        .SELW    (SELW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock          (clock),
        .hardreset_n    (hardreset_n),
        .req            (req),
        .req_type       (req_type),
        .req_code       (req_code),
        .req_typedata   (req_typedata),
        .req_data       (req_data),
        .ack            (ack),
        .ack_err        (ack_err),
        .gen_start      (gen_start),
        .gen_typeoficmp (gen_typeoficmp),
        .gen_code       (gen_code),
        .gen_typedata   (gen_typedata),
        .gen_inputdata  (gen_inputdata),
        .gen_out_valid  (gen_out_valid),
        .gen_out_word   (gen_out_word),
        .out_valid      (out_valid),
        .out_sop        (out_sop),
        .out_eop        (out_eop),
        .out_word       (out_word),
        .out_src        (out_src),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Expected outputs for one cycle.
    typedef struct {
        logic            busy;
        logic            gs;
        logic [31:0]     gid;
        logic [NREQ-1:0] ack;
        logic            aerr;
        logic            ov;
        logic            sop;
        logic            eop;
        logic [31:0]     ow;
        logic [SELW-1:0] src;
        logic [7:0]      typ;
        logic [7:0]      code;
        logic [31:0]     td;
    } exp_t;

    exp_t exp_q [int];
    int   cyc;
    int   n_checks;
    int   n_fail;
    bit   chk_en;
    int   m_rr;

    // Captured observations for literal checks.
    int              m_src;
    logic [NREQ-1:0] m_ack;
    logic            m_aerr;
    int              m_nov;
    int              m_nsop;
    int              m_neop;

    int exp111 [4];

    function automatic exp_t idle_exp();
        exp_t e;
        e.busy = 1'b0; e.gs = 1'b0; e.gid = '0; e.ack = '0; e.aerr = 1'b0;
        e.ov = 1'b0; e.sop = 1'b0; e.eop = 1'b0; e.ow = '0; e.src = '0;
        e.typ = '0; e.code = '0; e.td = '0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp_v);
        end
    endtask

    // Grant rule: first requesting index at or after the pointer, wrapping.
    function automatic int model_pick(input logic [NREQ-1:0] m, input int rr);
        int j;
`ifdef ICMP_ARB_PRIORITY_EN
        if (m[0]) return 0;
`endif
        for (int k = 0; k < int'(NREQ); k++) begin
            j = (rr + k) % int'(NREQ);
            if (m[j]) return j;
        end
        return -1;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Per-cycle comparison against the scheduled expectations.
    always @(negedge clock) begin : cmp
        exp_t e;
        if (chk_en) begin
            if (exp_q.exists(cyc)) e = exp_q[cyc];
            else e = idle_exp();
            chk("busy", 32'(busy), 32'(e.busy));
            chk("gen_start", 32'(gen_start), 32'(e.gs));
            chk("gen_inputdata", gen_inputdata, e.gid);
            chk("ack", 32'(ack), 32'(e.ack));
            if (e.ack != '0) chk("ack_err", 32'(ack_err), 32'(e.aerr));
            chk("out_valid", 32'(out_valid), 32'(e.ov));
            chk("out_sop", 32'(out_sop), 32'(e.sop));
            chk("out_eop", 32'(out_eop), 32'(e.eop));
            if (e.ov) chk("out_word", out_word, e.ow);
            if (e.busy) begin
                chk("out_src", 32'(out_src), 32'(e.src));
                chk("gen_typeoficmp", 32'(gen_typeoficmp), 32'(e.typ));
                chk("gen_code", 32'(gen_code), 32'(e.code));
                chk("gen_typedata", gen_typedata, e.td);
            end
        end
    end

    always @(negedge clock) begin
        if (gen_start) begin
            m_src  = int'(out_src);
            m_nov  = 0;
            m_nsop = 0;
            m_neop = 0;
        end
        if (out_valid) begin
            m_nov++;
            if (out_sop) m_nsop++;
            if (out_eop) m_neop++;
        end
        if (|ack) begin
            m_ack  = ack;
            m_aerr = ack_err;
        end
    end

    task automatic randomize_fields();
        for (int i = 0; i < int'(NREQ); i++) begin
            req_type[8*i +: 8]      = 8'($urandom);
            req_code[8*i +: 8]      = 8'($urandom);
            req_typedata[32*i +: 32] = $urandom;
            req_data[96*i +: 96]    = {$urandom, $urandom, $urandom};
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One message: nbeats==5 completes, fewer beats aborts by timeout.
    // gap_idx/gap_len force the idle gap before one beat; other gaps are 0..maxgap.
    task automatic run_msg(input logic [NREQ-1:0] mask, input int nbeats, input int maxgap,
                           input int gap_idx, input int gap_len, input bit drop_req);
        int          t, g, last, fin, gp;
        int          bc [5];
        logic [31:0] bw [5];
        logic [7:0]  ty, cd;
        logic [31:0] td;
        logic [95:0] dw;
        bit          isb;
        exp_t        e;
        t = cyc;
        randomize_fields();
        req = mask;
        g   = model_pick(mask, m_rr);
        if (g < 0) begin
            chk("model_grant", 32'(mask), 32'(1));
            g = 0;
        end
        ty = req_type[8*g +: 8];
        cd = req_code[8*g +: 8];
        td = req_typedata[32*g +: 32];
        dw = req_data[96*g +: 96];
        last = t + 3;
        for (int i = 0; i < nbeats; i++) begin
            gp    = (i == gap_idx) ? gap_len : int'($urandom_range(maxgap, 0));
            bc[i] = last + 1 + gp;
            last  = bc[i];
            bw[i] = $urandom;
        end
        fin = (nbeats == 5) ? last + 1 : last + int'(TIMEOUT) + 1;
        for (int c = t + 1; c <= fin; c++) begin
            e      = idle_exp();
            e.busy = 1'b1;
            e.src  = SELW'(g);
            e.typ  = ty;
            e.code = cd;
            e.td   = td;
            e.gs   = (c == t + 1);
            e.gid  = (c == t + 1) ? dw[95:64] : (c == t + 2) ? dw[63:32] :
                     (c == t + 3) ? dw[31:0] : 32'h0;
            for (int i = 0; i < nbeats; i++) begin
                if (c == bc[i] + 1) begin
                    e.ov  = 1'b1;
                    e.ow  = bw[i];
                    e.sop = (i == 0);
                    e.eop = (i == 4);
                end
            end
            if (c == fin) begin
                e.ack[g] = 1'b1;
                e.aerr   = (nbeats < 5);
            end
            exp_q[c] = e;
        end
        for (int c = t; c <= fin; c++) begin
            isb = 1'b0;
            for (int i = 0; i < nbeats; i++) begin
                if (c == bc[i]) begin
                    isb          = 1'b1;
                    gen_out_word = bw[i];
                end
            end
            if (isb) begin
                gen_out_valid = 1'b1;
            end else begin
                gen_out_word  = $urandom;
                gen_out_valid = (c <= t + 3 || c == fin) ? 1'($urandom_range(1, 0)) : 1'b0;
            end
            if (c == t + 1) randomize_fields();
            if (c == t + 2 && drop_req) req[g] = 1'b0;
            step();
        end
        req           = '0;
        gen_out_valid = 1'b0;
        m_rr          = (g + 1) % int'(NREQ);
    endtask

    task automatic idle(input int n);
        req = '0;
        for (int i = 0; i < n; i++) begin
            gen_out_valid = 1'($urandom_range(1, 0));
            gen_out_word  = $urandom;
            step();
        end
        gen_out_valid = 1'b0;
    endtask

    task automatic do_reset();
        chk_en        = 1'b0;
        req           = '0;
        gen_out_valid = 1'b0;
        hardreset_n   = 1'b0;
        step();
        step();
        chk("rst_ack", 32'(ack), 32'(0));
        chk("rst_ack_err", 32'(ack_err), 32'(0));
        chk("rst_gen_start", 32'(gen_start), 32'(0));
        chk("rst_gen_type", 32'(gen_typeoficmp), 32'(0));
        chk("rst_gen_code", 32'(gen_code), 32'(0));
        chk("rst_gen_typedata", gen_typedata, 32'(0));
        chk("rst_gen_inputdata", gen_inputdata, 32'(0));
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_sop", 32'(out_sop), 32'(0));
        chk("rst_out_eop", 32'(out_eop), 32'(0));
        chk("rst_out_word", out_word, 32'(0));
        chk("rst_out_src", 32'(out_src), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        hardreset_n = 1'b1;
        exp_q.delete();
        m_rr   = 0;
        chk_en = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] mask;
        int              nb, mg;
`ifdef ICMP_ARB_PRIORITY_EN
        exp111 = '{0, 0, 0, 0};
`else
        exp111 = '{0, 1, 2, 0};
`endif
        cyc = 0; n_checks = 0; n_fail = 0; chk_en = 1'b0; m_rr = 0;
        m_src = -1; m_ack = '0; m_aerr = 1'b0; m_nov = 0; m_nsop = 0; m_neop = 0;
        hardreset_n = 1'b0; req = '0; gen_out_valid = 1'b0; gen_out_word = '0;
        req_type = '0; req_code = '0; req_typedata = '0; req_data = '0;
        #3;
        do_reset();

        // Single requester 1, full echo.
        run_msg(3'b010, 5, 0, -1, 0, 1'b0);
        chk("t1_ack", 32'(m_ack), 32'(3'b010));
        chk("t1_ack_err", 32'(m_aerr), 32'(0));
        chk("t1_src", 32'(m_src), 32'(1));
        chk("t1_beats", 32'(m_nov), 32'(5));
        chk("t1_sops", 32'(m_nsop), 32'(1));
        chk("t1_eops", 32'(m_neop), 32'(1));

        // All requesting after reset, then 1 and 2 only.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_msg(3'b111, 5, 1, -1, 0, 1'b0);
            chk("t2_grant111", 32'(m_src), 32'(exp111[k]));
        end
        run_msg(3'b110, 5, 1, -1, 0, 1'b0);
        chk("t2_grant110_a", 32'(m_src), 32'(1));
        run_msg(3'b110, 5, 1, -1, 0, 1'b0);
        chk("t2_grant110_b", 32'(m_src), 32'(2));
        run_msg(3'b110, 5, 1, -1, 0, 1'b0);
        chk("t2_grant110_c", 32'(m_src), 32'(1));

        // Silent generator -> timeout.
        m_nov = 99;
        run_msg(3'b100, 0, 0, -1, 0, 1'b0);
        chk("t3_ack", 32'(m_ack), 32'(3'b100));
        chk("t3_ack_err", 32'(m_aerr), 32'(1));
        chk("t3_beats", 32'(m_nov), 32'(0));

        // Five-cycle gap between beats 2 and 3.
        run_msg(3'b001, 5, 0, 2, 5, 1'b0);
        chk("t4_beats", 32'(m_nov), 32'(5));
        chk("t4_eops", 32'(m_neop), 32'(1));
        chk("t4_ack_err", 32'(m_aerr), 32'(0));

        // Longest gap that must not time out.
        run_msg(3'b010, 5, 0, 3, int'(TIMEOUT) - 1, 1'b0);
        chk("t5_beats", 32'(m_nov), 32'(5));
        chk("t5_ack_err", 32'(m_aerr), 32'(0));

        // Abort after three beats, request dropped mid-message.
        run_msg(3'b011, 3, 2, -1, 0, 1'b1);
        chk("t6_ack_err", 32'(m_aerr), 32'(1));
        chk("t6_beats", 32'(m_nov), 32'(3));
        chk("t6_eops", 32'(m_neop), 32'(0));

        // Asynchronous reset while beat 3 is on the output.
        do_reset();
        chk_en = 1'b0;
        randomize_fields();
        req = 3'b001;
        for (int i = 0; i < 4; i++) step();
        gen_out_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            gen_out_word = $urandom;
            step();
        end
        chk("t7_pre_out_valid", 32'(out_valid), 32'(1));
        chk("t7_pre_busy", 32'(busy), 32'(1));
        #1;
        hardreset_n = 1'b0;
        #1;
        chk("t7_async_out_valid", 32'(out_valid), 32'(0));
        chk("t7_async_busy", 32'(busy), 32'(0));
        chk("t7_async_ack", 32'(ack), 32'(0));
        chk("t7_async_sop", 32'(out_sop), 32'(0));
        step();
        gen_out_valid = 1'b0;
        req           = '0;
        hardreset_n   = 1'b1;
        exp_q.delete();
        m_rr   = 0;
        chk_en = 1'b1;
        step();
        run_msg(3'b111, 5, 0, -1, 0, 1'b0);
        chk("t7_regrant_src", 32'(m_src), 32'(0));
        chk("t7_regrant_ack", 32'(m_ack), 32'(3'b001));

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(4, 0) == 0) idle(int'($urandom_range(3, 1)));
            mask = NREQ'($urandom_range((1 << NREQ) - 1, 1));
            nb   = ($urandom_range(4, 0) != 0) ? 5 : int'($urandom_range(4, 0));
            mg   = ($urandom_range(3, 0) == 0) ? int'(TIMEOUT) - 1 : 2;
            run_msg(mask, nb, mg, -1, 0, 1'($urandom_range(1, 0)));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
